// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared processor constants, fetch state type and instruction field positions
package cpu_pkg;

    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 8;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    // Instruction field positions, shared with the decoder
    localparam int COND_HI   = 15;
    localparam int COND_LO   = 14;
    localparam int OPCODE_HI = 13;
    localparam int OPCODE_LO = 11;
    localparam int RD_HI     = 10;
    localparam int RD_LO     = 8;
    localparam int RS1_HI    = 7;
    localparam int RS1_LO    = 5;
    localparam int RS2_HI    = 4;
    localparam int RS2_LO    = 2;
    localparam int SHAMT_HI  = 1;
    localparam int SHAMT_LO  = 0;

    function automatic logic [2:0] instr_opcode(input logic [INSTR_W-1:0] instr);
        return instr[OPCODE_HI:OPCODE_LO];
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - memory, redirect and decoder signals of the fetch stage
interface instruction_fetch_if #(
    parameter int ADDR_W  = cpu_pkg::ADDR_W,
    parameter int INSTR_W = cpu_pkg::INSTR_W
);

    logic               mem_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_ready;
    logic               mem_rvalid;
    logic [INSTR_W-1:0] mem_rdata;
    logic               branch_taken;
    logic [ADDR_W-1:0]  branch_target;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] raw_instruction;
    logic [ADDR_W-1:0]  instr_pc;

    modport master (
        output mem_req, mem_addr, instr_valid, raw_instruction, instr_pc,
        input  mem_ready, mem_rvalid, mem_rdata, branch_taken, branch_target, instr_ready
    );

    modport slave (
        input  mem_req, mem_addr, instr_valid, raw_instruction, instr_pc,
        output mem_ready, mem_rvalid, mem_rdata, branch_taken, branch_target, instr_ready
    );

endinterface

// File: rtl/instruction_fetch_fifo.sv
// rtl/instruction_fetch_fifo.sv - flop-based prefetch circular buffer with flush
module fetch_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  logic [WIDTH-1:0]        wdata,
    output logic [WIDTH-1:0]        rdata,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] entries [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Flush wins over both push and pop
    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && (count != '0);
    assign rdata   = entries[rd_ptr];

    // Pointers and occupancy; power-of-2 depth lets pointers wrap naturally
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage only; stale contents are never visible because empty reads are masked upstream
    always_ff @(posedge clk) begin
        if (do_push) entries[wr_ptr] <= wdata;
    end

    // The fetch FSM reserves a slot per outstanding request, so a full push is a design bug
    assert property (@(posedge clk) disable iff (!reset_n) !(do_push && !do_pop && count == FULL));

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: one-outstanding memory reads into a prefetch FIFO
module instruction_fetch #(
    parameter int ADDR_W     = cpu_pkg::ADDR_W,
    parameter int INSTR_W    = cpu_pkg::INSTR_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    instruction_fetch_if.master  bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    cpu_pkg::fetch_state_t      state;
    cpu_pkg::fetch_state_t      state_next;
    logic [ADDR_W-1:0]          pc;
    logic [ADDR_W-1:0]          pc_next;
    logic                       mem_req_q;
    logic [ADDR_W-1:0]          mem_addr_q;
    logic [CNT_W-1:0]           count;
    logic [CNT_W-1:0]           count_next;
    logic [INSTR_W+ADDR_W-1:0]  head;
    logic                       flush;
    logic                       accept;
    logic                       push;
    logic                       pop;
    logic                       valid;

    assign flush  = bus.branch_taken;
    assign accept = mem_req_q && bus.mem_ready;
    assign valid  = (count != '0);
    // mem_addr holds the accepted address through WAIT, so it tags the returning word
    assign push   = (state == cpu_pkg::WAIT) && bus.mem_rvalid && !flush;
    assign pop    = valid && bus.instr_ready && !flush;

    assign count_next = flush ? '0 : (count + CNT_W'(push) - CNT_W'(pop));

    fetch_fifo #(
        .WIDTH (INSTR_W + ADDR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .wdata   ({bus.mem_rdata, mem_addr_q}),
        .rdata   (head),
        .count   (count)
    );

    // Next state and pc; a redirect drains only if a request is still in flight after this edge
    always_comb begin
        state_next = state;
        pc_next    = pc;
        if (flush) begin
            pc_next = bus.branch_target;
            if ((state == cpu_pkg::FETCH && accept) ||
                (state != cpu_pkg::FETCH && !bus.mem_rvalid)) begin
                state_next = cpu_pkg::DRAIN;
            end else begin
                state_next = cpu_pkg::FETCH;
            end
        end else begin
            case (state)
                cpu_pkg::FETCH: begin
                    if (accept) begin
                        pc_next    = pc + ADDR_W'(1);
                        state_next = cpu_pkg::WAIT;
                    end
                end
                cpu_pkg::WAIT, cpu_pkg::DRAIN: begin
                    if (bus.mem_rvalid) state_next = cpu_pkg::FETCH;
                end
                default: state_next = cpu_pkg::FETCH;
            endcase
        end
    end

    // Fetch FSM with registered request; request is raised on the edge that enters FETCH with space
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= cpu_pkg::FETCH;
            pc         <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            mem_req_q <= (state_next == cpu_pkg::FETCH) && (count_next < DEPTH_C);
            if (state_next == cpu_pkg::FETCH) mem_addr_q <= pc_next;
        end
    end

    assign bus.mem_req         = mem_req_q;
    assign bus.mem_addr        = mem_addr_q;
    assign bus.instr_valid     = valid;
    assign bus.raw_instruction = valid ? head[INSTR_W+ADDR_W-1:ADDR_W] : '0;
    assign bus.instr_pc        = valid ? head[ADDR_W-1:0] : '0;

endmodule
